qam16_mapper: RTL and testbench
===============================

# qam16_mapper

Upstream symbol stage of the QAM transmit chain. Accepts a byte stream over a valid/ready handshake, splits each byte into two 16-QAM symbols, Gray-maps each symbol to signed I/Q amplitude levels, and holds each symbol for a fixed number of clocks. Its outputs feed the carrier mixer, where they multiply the cosine/sine NCO outputs.

## Interface
- AMP_WIDTH, 16: width of the signed two's-complement I/Q level outputs.
- SYM_LEN, 64: clocks per symbol; must be ≥ 2.
- LEVEL_UNIT, 8192: amplitude of level ±1; ±3 maps to ±3·LEVEL_UNIT. Constraint: 3·LEVEL_UNIT < 2^(AMP_WIDTH-1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  permits symbol output; sampled at symbol boundaries.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  equals ~buf_full; a byte transfers on a clk edge where in_valid && in_ready.
- i_level  out  AMP_WIDTH  signed in-phase level.
- q_level  out  AMP_WIDTH  signed quadrature level.
- sym_start  out  1  high on the first clock of each emitted symbol.
- underflow  out  1  one-clock pulse when a symbol boundary finds no data.

## Operation
- Registers:
  - buf_data/buf_full: one-byte skid buffer.
  - cur_lo/lo_pend: low nibble awaiting emission.
  - cnt: symbol counter, width $clog2(SYM_LEN).
  - state: IDLE or RUN.
- Symbol split:
  - High nibble is emitted first, then the low nibble.
  - Within a nibble b3..b0, bits b3b2 select I and bits b1b0 select Q.
- Gray map (2 bits → level): 00 → −3U, 01 → −1U, 11 → +1U, 10 → +3U, where U = LEVEL_UNIT.
- A boundary event ("tick") occurs when either:
  - state=IDLE and enable=1 and (lo_pend or buf_full), or
  - state=RUN and cnt=SYM_LEN−1.
- At a tick, the first matching rule applies:
  1. enable=0 (RUN only): go to IDLE; levels become 0; lo_pend and buffer are kept.
  2. lo_pend: emit cur_lo; clear lo_pend.
  3. buf_full: emit buf_data[7:4]; set cur_lo=buf_data[3:0] and lo_pend=1; clear buf_full.
  4. Otherwise (RUN only): go to IDLE; levels become 0; pulse underflow.
- Any emission sets state=RUN, cnt=0 and sym_start=1. Outside a tick, cnt increments while in RUN.
- A byte accepted on a clk edge sets buf_full. Because in_ready is low while the buffer is full, accept and consume never occur on the same edge.
- Reset value of every output: i_level=0, q_level=0, sym_start=0, underflow=0, in_ready=1.
- Reset value of internal state: state=IDLE, cnt=0, buf_full=0, lo_pend=0.
- Reset mid-symbol aborts the symbol and discards both the buffered byte and the pending nibble.

## Timing
- Byte accepted at edge E while IDLE with enable=1: levels and sym_start appear after edge E+1.
- Each symbol is held exactly SYM_LEN clocks. The low nibble follows at E+1+SYM_LEN.
- in_ready returns high the cycle after the byte moves out of the buffer.
- Gap-free output requires the next byte to be accepted before the low-nibble symbol ends. In steady state the block consumes one byte per 2·SYM_LEN clocks.
- Dropping enable mid-symbol has no effect until that symbol's final cycle; the block then goes IDLE with zero levels.
- Re-enable: the first emission appears one edge later, taking the pending low nibble first if one exists.
- underflow and sym_start never assert in the same cycle.
- All outputs are registered; there is no combinational path from in_valid to any output except in_ready (which depends on buf_full only).

## Structure
- Shared package qam_pkg holds:
  - the state enum (IDLE, RUN);
  - Gray code constants GRAY_M3=2'b00, GRAY_M1=2'b01, GRAY_P1=2'b11, GRAY_P3=2'b10.
- Natural sub-module: qam_level_lut, a combinational mapping of 2 bits to a signed level, parameterised by AMP_WIDTH and LEVEL_UNIT. It is instantiated twice, once for I and once for Q.

## Test plan
All values below use SYM_LEN=4 and LEVEL_UNIT=8192.
1. Reset: all outputs 0 and in_ready=1; holding in_valid=1 with enable=0 fills the buffer, after which in_ready=0 and levels stay 0.
2. Single byte 0x2D with enable=1:
   - I=−24576, Q=+24576 for 4 clocks;
   - then I=+8192, Q=−8192 for 4 clocks;
   - then underflow pulses once and levels return to 0.
3. Back-to-back bytes 0x00, 0xFF, 0xA5 presented continuously: 6 contiguous symbols, sym_start every 4th clock, no underflow.
4. enable dropped on the 2nd cycle of the high-nibble symbol of 0x2D: symbol completes its 4 clocks, then levels are 0. Re-enable: low nibble (+8192/−8192) is emitted next.
5. rst_n asserted mid-symbol with the buffer full: outputs reset immediately. After release, the buffered byte has been discarded and levels stay 0.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared types and constants for the 16-QAM symbol mapper.
// Gray codes give the 2-bit pattern for each amplitude level.
package qam_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

endpackage

// File: rtl/qam_level_lut.sv
// Combinational Gray-code to signed amplitude lookup for one QAM axis.
// A level of +/-1 equals LEVEL_UNIT; +/-3 equals 3*LEVEL_UNIT.
module qam_level_lut
  import qam_pkg::*;
#(
  parameter int AMP_WIDTH  = 16,
  parameter int LEVEL_UNIT = 8192
) (
  input  logic        [1:0]           code,
  output logic signed [AMP_WIDTH-1:0] level
);

  localparam logic signed [AMP_WIDTH-1:0] LVL1 = AMP_WIDTH'(LEVEL_UNIT);
  localparam logic signed [AMP_WIDTH-1:0] LVL3 = AMP_WIDTH'(3 * LEVEL_UNIT);

  always_comb begin
    level = '0;
    case (code)
      GRAY_M3: level = -LVL3;
      GRAY_M1: level = -LVL1;
      GRAY_P1: level = LVL1;
      GRAY_P3: level = LVL3;
      default: level = '0;
    endcase
  end

endmodule

// File: rtl/qam16_mapper.sv
// Byte-stream to 16-QAM symbol mapper: two Gray-mapped symbols per byte,
// high nibble first, each held for SYM_LEN clocks, behind a one-byte skid buffer.
module qam16_mapper
  import qam_pkg::*;
#(
  parameter int AMP_WIDTH  = 16,
  parameter int SYM_LEN    = 64,
  parameter int LEVEL_UNIT = 8192
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic        [7:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [AMP_WIDTH-1:0] i_level,
  output logic signed [AMP_WIDTH-1:0] q_level,
  output logic                        sym_start,
  output logic                        underflow
);

  localparam int CNT_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);

  state_t                      state, state_n;
  logic        [CNT_W-1:0]     cnt, cnt_n;
  logic        [7:0]           buf_data;
  logic                        buf_full, buf_full_n;
  logic        [3:0]           cur_lo, cur_lo_n;
  logic                        lo_pend, lo_pend_n;
  logic signed [AMP_WIDTH-1:0] i_level_n, q_level_n;
  logic                        sym_start_n, underflow_n;
  logic                        accept;
  logic                        tick;
  logic        [3:0]           emit_nib;
  logic signed [AMP_WIDTH-1:0] lut_i, lut_q;

  assign in_ready = ~buf_full;
  assign accept   = in_valid & ~buf_full;
  // A pending low nibble always goes out before the next buffered byte.
  assign emit_nib = lo_pend ? cur_lo : buf_data[7:4];

  qam_level_lut #(
    .AMP_WIDTH (AMP_WIDTH),
    .LEVEL_UNIT(LEVEL_UNIT)
  ) u_lut_i (
    .code (emit_nib[3:2]),
    .level(lut_i)
  );

  qam_level_lut #(
    .AMP_WIDTH (AMP_WIDTH),
    .LEVEL_UNIT(LEVEL_UNIT)
  ) u_lut_q (
    .code (emit_nib[1:0]),
    .level(lut_q)
  );

  always_comb begin
    tick = 1'b0;
    case (state)
      IDLE:    tick = enable & (lo_pend | buf_full);
      RUN:     tick = (cnt == CNT_LAST);
      default: tick = 1'b0;
    endcase
  end

  // Boundary decisions in priority order: stop, low nibble, new byte, underflow.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    buf_full_n  = buf_full;
    cur_lo_n    = cur_lo;
    lo_pend_n   = lo_pend;
    i_level_n   = i_level;
    q_level_n   = q_level;
    sym_start_n = 1'b0;
    underflow_n = 1'b0;

    if (accept) begin
      buf_full_n = 1'b1;
    end

    if (tick) begin
      if (!enable) begin
        state_n   = IDLE;
        i_level_n = '0;
        q_level_n = '0;
      end else if (lo_pend || buf_full) begin
        state_n     = RUN;
        cnt_n       = '0;
        sym_start_n = 1'b1;
        i_level_n   = lut_i;
        q_level_n   = lut_q;
        if (lo_pend) begin
          lo_pend_n = 1'b0;
        end else begin
          cur_lo_n   = buf_data[3:0];
          lo_pend_n  = 1'b1;
          buf_full_n = 1'b0;
        end
      end else begin
        state_n     = IDLE;
        i_level_n   = '0;
        q_level_n   = '0;
        underflow_n = 1'b1;
      end
    end else if (state == RUN) begin
      cnt_n = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      buf_full  <= 1'b0;
      cur_lo    <= '0;
      lo_pend   <= 1'b0;
      i_level   <= '0;
      q_level   <= '0;
      sym_start <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      buf_full  <= buf_full_n;
      cur_lo    <= cur_lo_n;
      lo_pend   <= lo_pend_n;
      i_level   <= i_level_n;
      q_level   <= q_level_n;
      sym_start <= sym_start_n;
      underflow <= underflow_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data <= '0;
    end else if (accept) begin
      buf_data <= in_data;
    end
  end

endmodule

// File: tb/tb_qam16_mapper.sv
// Scoreboard bench for qam16_mapper: accepted bytes become expected symbols in a
// queue; a negedge monitor checks symbol timing, levels, underflow and in_ready.
module tb_qam16_mapper;

  localparam int AMP_WIDTH  = 16;
  localparam int SYM_LEN    = 4;
  localparam int LEVEL_UNIT = 8192;

  typedef struct packed {
    int i;
    int q;
    bit hi;
  } exp_sym_t;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        enable;
  logic        [7:0]           in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [AMP_WIDTH-1:0] i_level;
  logic signed [AMP_WIDTH-1:0] q_level;
  logic                        sym_start;
  logic                        underflow;

  int       checks = 0;
  int       errors = 0;
  exp_sym_t exp_q[$];
  bit       en_snap = 1'b0;
  bit       avail_snap = 1'b0;
  int       rem = 0;
  bit       running = 1'b0;
  int       held_i = 0;
  int       held_q = 0;
  bit       rand_done = 1'b0;

  qam16_mapper #(
    .AMP_WIDTH (AMP_WIDTH),
    .SYM_LEN   (SYM_LEN),
    .LEVEL_UNIT(LEVEL_UNIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .i_level  (i_level),
    .q_level  (q_level),
    .sym_start(sym_start),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic int gray_amp(input logic [1:0] code);
    int tbl[4];
    tbl = '{-3, -1, 3, 1};
    return tbl[code] * LEVEL_UNIT;
  endfunction

  function automatic bit buffer_expected_full();
    foreach (exp_q[k]) if (exp_q[k].hi) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bit accepted = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    #1 in_valid = 1'b0;
    checkOutput("byte_accepted", accepted, 1);
  endtask

  task automatic waitSym(input int maxc);
    bit found = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (sym_start) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("wait_sym_start", found, 1);
  endtask

  task automatic waitUnderflow(input int maxc);
    bit found = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (underflow) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("wait_underflow", found, 1);
  endtask

  // Every accepted byte queues its two symbols; boundary inputs are snapshotted per edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      en_snap    <= 1'b0;
      avail_snap <= 1'b0;
    end else begin
      en_snap    <= enable;
      avail_snap <= (exp_q.size() != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back('{i: gray_amp(in_data[7:6]), q: gray_amp(in_data[5:4]), hi: 1'b1});
        exp_q.push_back('{i: gray_amp(in_data[3:2]), q: gray_amp(in_data[1:0]), hi: 1'b0});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_i_level", i_level, 0);
      checkOutput("rst_q_level", q_level, 0);
      checkOutput("rst_sym_start", sym_start, 0);
      checkOutput("rst_underflow", underflow, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      exp_q.delete();
      rem     <= 0;
      running <= 1'b0;
    end else begin
      if (rem > 0) begin
        checkOutput("mid_sym_start", sym_start, 0);
        checkOutput("mid_underflow", underflow, 0);
        checkOutput("hold_i_level", i_level, held_i);
        checkOutput("hold_q_level", q_level, held_q);
        rem <= rem - 1;
      end else begin
        checkOutput("sym_start", sym_start, (en_snap && avail_snap) ? 1 : 0);
        checkOutput("underflow", underflow, (running && en_snap && !avail_snap) ? 1 : 0);
        if (sym_start) begin
          checkOutput("scoreboard_has_entry", (exp_q.size() != 0) ? 1 : 0, 1);
          if (exp_q.size() != 0) begin
            checkOutput("start_i_level", i_level, exp_q[0].i);
            checkOutput("start_q_level", q_level, exp_q[0].q);
            held_i <= exp_q[0].i;
            held_q <= exp_q[0].q;
            void'(exp_q.pop_front());
          end
          rem     <= SYM_LEN - 1;
          running <= 1'b1;
        end else begin
          checkOutput("idle_i_level", i_level, 0);
          checkOutput("idle_q_level", q_level, 0);
          running <= 1'b0;
        end
      end
      checkOutput("in_ready", in_ready, buffer_expected_full() ? 0 : 1);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] buffer fill with enable low");
    @(posedge clk);
    #1;
    applyStimulus(8'h5A);
    in_data  = 8'h77;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t1_in_ready", in_ready, 0);
    checkOutput("t1_i_level", i_level, 0);
    checkOutput("t1_q_level", q_level, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] single byte 0x2D");
    enable = 1'b1;
    applyStimulus(8'h2D);
    waitSym(4);
    checkOutput("t2_hi_i", i_level, -24576);
    checkOutput("t2_hi_q", q_level, 24576);
    waitSym(SYM_LEN + 1);
    checkOutput("t2_lo_i", i_level, 8192);
    checkOutput("t2_lo_q", q_level, -8192);
    waitUnderflow(SYM_LEN + 1);
    checkOutput("t2_uf_i", i_level, 0);
    checkOutput("t2_uf_q", q_level, 0);

    $display("[TB] back-to-back bytes");
    @(posedge clk);
    #1;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'hA5);
    waitUnderflow(8 * SYM_LEN);
    checkOutput("t3_uf_i", i_level, 0);

    $display("[TB] enable drop mid-symbol");
    @(posedge clk);
    #1;
    applyStimulus(8'h2D);
    waitSym(4);
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (SYM_LEN + 3) @(negedge clk);
    checkOutput("t4_off_i", i_level, 0);
    checkOutput("t4_off_q", q_level, 0);
    checkOutput("t4_off_ready", in_ready, 1);
    @(posedge clk);
    #1 enable = 1'b1;
    waitSym(3);
    checkOutput("t4_lo_i", i_level, 8192);
    checkOutput("t4_lo_q", q_level, -8192);
    waitUnderflow(SYM_LEN + 2);

    $display("[TB] reset mid-symbol with buffer full");
    @(posedge clk);
    #1;
    applyStimulus(8'h3C);
    applyStimulus(8'h81);
    checkOutput("t5_buf_full", in_ready, 0);
    checkOutput("t5_run_i", i_level, -24576);
    rst_n = 1'b0;
    #2;
    checkOutput("t5_rst_i", i_level, 0);
    checkOutput("t5_rst_q", q_level, 0);
    checkOutput("t5_rst_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3 * SYM_LEN) @(negedge clk);
    checkOutput("t5_after_i", i_level, 0);
    checkOutput("t5_after_q", q_level, 0);

    $display("[TB] randomized traffic");
    @(posedge clk);
    #1;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          repeat ($urandom_range(0, 10)) @(posedge clk);
          #1;
          applyStimulus(8'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          repeat ($urandom_range(1, 25)) @(posedge clk);
          #1 enable = ($urandom_range(0, 3) != 0);
        end
        enable = 1'b1;
      end
    join

    in_valid = 1'b0;
    enable   = 1'b1;
    repeat (10 * SYM_LEN) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
